// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-master system bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam int MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/system_bus_arbiter.sv
// Arbitrates a core (m0) and a GEMM engine (m1) onto one registered system bus,
// with bounded hold fairness and a tag pipeline that routes read data back.
module system_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_rdwr,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_mask,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_rdwr,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_mask,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  bus_en,
    output logic                  bus_rdwr,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_mask,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int                 MASK_W   = DATA_W / 8;
    localparam int                 HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t         state, state_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    master_id_t         last_owner;

    logic               acc0, acc1, acc_any, acc_rd;
    master_id_t         acc_id;

    logic               rd_vld_p1, rd_vld_p2;
    master_id_t         rd_id_p1, rd_id_p2;

    assign acc0    = m0_req & m0_gnt;
    assign acc1    = m1_req & m1_gnt;
    assign acc_any = acc0 | acc1;
    assign acc_id  = acc1;
    assign acc_rd  = acc1 ? ~m1_rdwr : (acc0 & ~m0_rdwr);

    // Count includes the beat accepted this cycle so the owner gets exactly MAX_HOLD beats.
    always_comb begin
        hold_nxt = hold_cnt;
        if (acc_any && hold_cnt != HOLD_MAX)
            hold_nxt = hold_cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_nxt = (last_owner == 1'b0) ? OWN_M1 : OWN_M0;
                else if (m0_req)
                    state_nxt = OWN_M0;
                else if (m1_req)
                    state_nxt = OWN_M1;
            end
            OWN_M0: begin
                if (!m0_req)
                    state_nxt = m1_req ? OWN_M1 : IDLE;
                else if (m1_req && hold_nxt == HOLD_MAX)
                    state_nxt = OWN_M1;
            end
            OWN_M1: begin
                if (!m1_req)
                    state_nxt = m0_req ? OWN_M0 : IDLE;
                else if (m0_req && hold_nxt == HOLD_MAX)
                    state_nxt = OWN_M0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
        end else begin
            state    <= state_nxt;
            m0_gnt   <= (state_nxt == OWN_M0);
            m1_gnt   <= (state_nxt == OWN_M1);
            hold_cnt <= (state_nxt != state) ? '0 : hold_nxt;
            if (state_nxt == OWN_M0 && state != OWN_M0)
                last_owner <= 1'b0;
            else if (state_nxt == OWN_M1 && state != OWN_M1)
                last_owner <= 1'b1;
        end
    end

    // Stage p1: accepted beat registered onto the bus, read tag captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_en    <= 1'b0;
            bus_rdwr  <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_mask  <= '0;
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= 1'b0;
        end else begin
            bus_en    <= acc_any;
            rd_vld_p1 <= acc_rd;
            rd_id_p1  <= acc_id;
            if (acc_any) begin
                bus_rdwr  <= acc1 ? m1_rdwr  : m0_rdwr;
                bus_addr  <= acc1 ? m1_addr  : m0_addr;
                bus_wdata <= acc1 ? m1_wdata : m0_wdata;
                bus_mask  <= acc1 ? m1_mask  : m0_mask;
            end
        end
    end

    // Stage p2: tag aligned with slave read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p2 <= 1'b0;
            rd_id_p2  <= 1'b0;
        end else begin
            rd_vld_p2 <= rd_vld_p1;
            rd_id_p2  <= rd_id_p1;
        end
    end

    assign m0_rvalid = rd_vld_p2 & (rd_id_p2 == 1'b0);
    assign m1_rvalid = rd_vld_p2 & (rd_id_p2 == 1'b1);
    assign m0_rdata  = m0_rvalid ? bus_rdata : {DATA_W{1'b0}};
    assign m1_rdata  = m1_rvalid ? bus_rdata : {DATA_W{1'b0}};

    logic unused_mask_w;
    assign unused_mask_w = (MASK_W == 0);

endmodule
